// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the nibble-serial link.
package serial_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = 32;
  localparam int NIBBLES_PER_WORD = 8;
  localparam int CNT_W            = $clog2(NIBBLES_PER_WORD);

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_e;

endpackage

// File: rtl/serial_receiver_if.sv
// Push/pop handshake bundle between the word assembler and its FIFO.
interface serial_receiver_if #(
  parameter int W     = 32,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic [W-1:0]  rd_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          drop;

  modport master (
    output push, push_data, pop,
    input  rd_data, full, empty, count, drop
  );

  modport slave (
    input  push, push_data, pop,
    output rd_data, full, empty, count, drop
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push while full is dropped unless
// a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset,
  serial_receiver_if.slave f
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = f.pop & ~w_empty;
  assign w_push  = f.push & (~w_full | w_pop);

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr] <= f.push_data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero when empty so stale storage never shows.
  assign f.rd_data = w_empty ? '0 : r_mem[r_rd];
  assign f.full    = w_full;
  assign f.empty   = w_empty;
  assign f.count   = r_count;
  assign f.drop    = f.push & w_full & ~w_pop;

endmodule

// File: rtl/serial_receiver.sv
// Reassembles MSB-first nibble stream into 32-bit words and queues them.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    ClkTx,
  input  logic [NIBBLE_W-1:0]     DIn,
  input  logic                    DInValid,
  input  logic                    ReadEn,
  input  logic                    Clear,
  output logic [WORD_W-1:0]       DOut,
  output logic                    DOutValid,
  output logic                    Full,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Overflow,
  output logic                    FrameErr
);

  serial_receiver_if #(.W(WORD_W), .DEPTH(DEPTH)) u_if ();

  sync_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .f     (u_if.slave)
  );

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic              r_clktx_q;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_ovf;
  logic              r_ferr;
  logic              w_cap;
  logic              w_push;
  logic              w_ferr_evt;

  assign w_cap = ClkTx & ~r_clktx_q & DInValid;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_ferr_evt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cap) begin
          w_shift_nxt = {{(WORD_W-NIBBLE_W){1'b0}}, DIn};
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (!DInValid) begin
          w_ferr_evt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_cap) begin
          w_shift_nxt = {r_shift[WORD_W-NIBBLE_W-1:0], DIn};
          if (r_cnt == CNT_W'(NIBBLES_PER_WORD-1)) begin
            w_push      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_clktx_q <= 1'b0;
      r_shift   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clktx_q <= ClkTx;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // A new error event beats a simultaneous Clear.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= u_if.drop  | (r_ovf  & ~Clear);
      r_ferr <= w_ferr_evt | (r_ferr & ~Clear);
    end
  end

  assign u_if.push      = w_push;
  assign u_if.push_data = w_shift_nxt;
  assign u_if.pop       = ReadEn;

  assign DOut      = u_if.rd_data;
  assign DOutValid = ~u_if.empty;
  assign Full      = u_if.full;
  assign Count     = u_if.count;
  assign Overflow  = r_ovf;
  assign FrameErr  = r_ferr;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with a queue-based reference model.
module tb_serial_receiver;

  localparam int DEPTH = 4;

  logic        Clk      = 1'b0;
  logic        Reset    = 1'b0;
  logic        ClkTx    = 1'b0;
  logic        DInValid = 1'b0;
  logic        Clear    = 1'b0;
  logic [3:0]  DIn      = 4'h0;
  logic [31:0] DOut;
  logic        DOutValid;
  logic        Full;
  logic [2:0]  Count;
  logic        Overflow;
  logic        FrameErr;

  int total = 0;
  int bad   = 0;

  serial_receiver_if #(.W(32), .DEPTH(DEPTH)) host ();

  assign host.rd_data   = DOut;
  assign host.full      = Full;
  assign host.empty     = ~DOutValid;
  assign host.count     = Count;
  assign host.drop      = Overflow;
  assign host.push      = 1'b0;
  assign host.push_data = '0;

  serial_receiver #(.DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ClkTx     (ClkTx),
    .DIn       (DIn),
    .DInValid  (DInValid),
    .ReadEn    (host.pop),
    .Clear     (Clear),
    .DOut      (DOut),
    .DOutValid (DOutValid),
    .Full      (Full),
    .Count     (Count),
    .Overflow  (Overflow),
    .FrameErr  (FrameErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: nibble list for the word in flight, word queue.
  bit          m_prev;
  logic [3:0]  m_nib[$];
  logic [31:0] m_q[$];
  bit          m_ovf;
  bit          m_fe;

  always @(posedge Clk) begin
    bit          rise;
    bit          pop;
    bit          push;
    bit          drop;
    bit          fe_evt;
    logic [31:0] w;
    if (!Reset) begin
      m_prev = 0;
      m_nib.delete();
      m_q.delete();
      m_ovf = 0;
      m_fe  = 0;
    end else begin
      rise   = ClkTx && !m_prev;
      m_prev = ClkTx;
      pop    = host.pop && (m_q.size() > 0);
      push   = 0;
      drop   = 0;
      fe_evt = 0;
      w      = '0;
      if (m_nib.size() > 0 && !DInValid) begin
        m_nib.delete();
        fe_evt = 1;
      end else if (rise && DInValid) begin
        m_nib.push_back(DIn);
        if (m_nib.size() == 8) begin
          foreach (m_nib[i]) w = {w[27:0], m_nib[i]};
          m_nib.delete();
          push = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else drop = 1;
      end
      m_ovf = drop   ? 1'b1 : (Clear ? 1'b0 : m_ovf);
      m_fe  = fe_evt ? 1'b1 : (Clear ? 1'b0 : m_fe);
    end
    #1;
    chk("dout",  DOut, (m_q.size() > 0) ? m_q[0] : 32'h0);
    chk("valid", 32'(DOutValid), 32'(m_q.size() > 0));
    chk("full",  32'(Full), 32'(m_q.size() == DEPTH));
    chk("count", 32'(Count), 32'(m_q.size()));
    chk("ovf",   32'(Overflow), 32'(m_ovf));
    chk("ferr",  32'(FrameErr), 32'(m_fe));
  end

  task automatic nib(input logic [3:0] d, input int hi, input bit pop);
    DIn   = d;
    ClkTx = 1'b1;
    if (pop) host.pop = 1'b1;
    repeat (hi) @(negedge Clk);
    host.pop = 1'b0;
    ClkTx    = 1'b0;
    @(negedge Clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int hi,
                           input bit pop_last);
    DInValid = 1'b1;
    for (int i = 0; i < 8; i++)
      nib(w[31-4*i -: 4], hi, pop_last && (i == 7));
    DInValid = 1'b0;
  endtask

  task automatic rd();
    host.pop = 1'b1;
    @(negedge Clk);
    host.pop = 1'b0;
  endtask

  task automatic clr();
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
  endtask

  initial begin
    host.pop = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_valid", 32'(DOutValid), 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    Reset = 1'b1;
    @(negedge Clk);

    send_word(32'h1234_5678, 1, 0);
    chk("w1_dout", DOut, 32'h1234_5678);
    chk("w1_count", 32'(Count), 32'h1);
    rd();
    chk("w1_pop_valid", 32'(DOutValid), 32'h0);
    chk("w1_pop_count", 32'(Count), 32'h0);

    DInValid = 1'b1;
    nib(4'h9, 1, 0);
    nib(4'h8, 1, 0);
    nib(4'h7, 1, 0);
    DInValid = 1'b0;
    @(negedge Clk);
    chk("abort_ferr", 32'(FrameErr), 32'h1);
    chk("abort_count", 32'(Count), 32'h0);
    send_word(32'hDEAD_BEEF, 1, 0);
    chk("abort_next", DOut, 32'hDEAD_BEEF);
    rd();
    clr();
    chk("clear_ferr", 32'(FrameErr), 32'h0);

    for (int k = 0; k < 5; k++) send_word(32'(k), 1, 0);
    chk("ovf_full", 32'(Full), 32'h1);
    chk("ovf_flag", 32'(Overflow), 32'h1);
    chk("ovf_count", 32'(Count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_rd", DOut, 32'(k));
      rd();
    end
    chk("ovf_empty", 32'(DOutValid), 32'h0);
    clr();
    chk("clear_ovf", 32'(Overflow), 32'h0);

    for (int k = 0; k < 4; k++) send_word(32'(k), 1, 0);
    send_word(32'h4, 1, 1);
    chk("pp_count", 32'(Count), 32'h4);
    chk("pp_ovf", 32'(Overflow), 32'h0);
    for (int k = 1; k < 5; k++) begin
      chk("pp_rd", DOut, 32'(k));
      rd();
    end
    chk("pp_empty", 32'(DOutValid), 32'h0);

    send_word(32'hCAFE_F00D, 5, 0);
    chk("held_dout", DOut, 32'hCAFE_F00D);
    chk("held_count", 32'(Count), 32'h1);
    rd();

    send_word(32'h1111_1111, 1, 0);
    DInValid = 1'b1;
    nib(4'hF, 1, 0);
    nib(4'hE, 1, 0);
    nib(4'hD, 1, 0);
    nib(4'hC, 1, 0);
    Reset    = 1'b0;
    DInValid = 1'b0;
    @(negedge Clk);
    chk("mid_rst_dout", DOut, 32'h0);
    chk("mid_rst_valid", 32'(DOutValid), 32'h0);
    chk("mid_rst_count", 32'(Count), 32'h0);
    Reset = 1'b1;
    @(negedge Clk);
    send_word(32'hA5C3_0F96, 1, 0);
    chk("post_rst_dout", DOut, 32'hA5C3_0F96);
    chk("post_rst_count", 32'(Count), 32'h1);
    rd();

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
